gate_truth_table_sequencer: RTL
===============================

GATE_TRUTH_TABLE_SEQUENCER -- requirements
Module: gate_truth_table_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles each input vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 op  input  2  expected function: 00 NAND3, 01 NOR3, 10 XOR3, 11 AND3; latched when start is accepted.
REQ-006 a  output  1  gate input a, registered; MSB of the current vector.
REQ-007 b  output  1  gate input b, registered.
REQ-008 c  output  1  gate input c, registered; LSB of the current vector.
REQ-009 d  input  1  gate output returned from the gate under test.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 pass  output  1  1 = all 8 vectors matched; valid from done until next accepted start.
REQ-013 err_count  output  4  number of mismatching vectors in current/last run, 0..8.
REQ-014 fail_valid  output  1  at least one mismatch seen in current/last run.
REQ-015 fail_vec  output  3  {a,b,c} of first mismatching vector; 0 when fail_valid=0.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, CHECK, DONE.
REQ-017 IDLE: start=1 at an edge -> DRIVE; latch op; vector index v=0; clear err_count, fail_valid, fail_vec, pass.
REQ-018 {a,b,c} SHALL equal v in every DRIVE and CHECK cycle; outputs are registered, so v appears on the first DRIVE cycle.
REQ-019 DRIVE SHALL last exactly SETTLE_CYCLES cycles (internal 4-bit settle counter), then -> CHECK.
REQ-020 CHECK (1 cycle): sample d; expected = NAND ~(a&b&c), NOR ~(a|b|c), XOR a^b^c, AND a&b&c per latched op.
REQ-021 Mismatch in CHECK: err_count+1; if fail_valid=0, set fail_valid=1 and fail_vec=v; later mismatches do not change fail_vec.
REQ-022 CHECK with v<7: v+1, -> DRIVE; with v=7: -> DONE (v does not wrap into a 9th vector).
REQ-023 DONE (1 cycle): done=1, busy=0, pass=(err_count==0 including the final CHECK result); -> IDLE.
REQ-024 busy SHALL be 1 in DRIVE and CHECK, 0 in IDLE and DONE.
REQ-025 Run length: start accepted at edge k -> done high in cycle k+1+8*(SETTLE_CYCLES+1).
REQ-026 start while busy or in DONE SHALL be ignored; start held high continuously SHALL launch a new run on the first IDLE cycle after DONE.
REQ-027 op changes during a run SHALL have no effect.
REQ-028 err_count, fail_valid, fail_vec, pass SHALL hold their values in IDLE until next accepted start.
REQ-029 In IDLE and DONE {a,b,c} SHALL hold 3'b000.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force state IDLE, v=0, settle counter 0, a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no done pulse; first start after rst_n rises begins a fresh run at v=0.

Verification
REQ-032 Ideal NAND3 model on d, op=00, SETTLE_CYCLES=2, start pulse at edge k -> vectors 0..7 in order, done at cycle k+25, pass=1, err_count=0, fail_valid=0.
REQ-033 NOR3 model, op=00 (NAND expected) -> mismatch at vectors 1..6 -> err_count=6, fail_vec=3'b001, fail_valid=1, pass=0.
REQ-034 d stuck at 1, op=10 (XOR) -> mismatches at v=0,3,5,6 -> err_count=4, fail_vec=3'b000, pass=0.
REQ-035 start re-pulsed during a run and op toggled mid-run -> no restart, done at original k+25, results per originally latched op.
REQ-036 rst_n low at vector 4 -> all outputs 0 same cycle, no done; new start -> full run from v=0 with pass=1 on ideal model.
REQ-037 SETTLE_CYCLES=1 and 15 with start held high -> done at k+17 / k+129 respectively, back-to-back runs with exactly one IDLE cycle between done and next busy.

Source files
------------

// File: rtl/gate_truth_table_sequencer.sv
// Purpose : exhaustive 3-input gate tester. Drives vectors 0..7 on {a,b,c}, holds each
//           for SETTLE_CYCLES, samples d for one cycle and scores it against the latched op.
// Latency : start accepted at edge k -> done pulse in cycle k+1+8*(SETTLE_CYCLES+1).
// Backpressure: none; start is only sampled in IDLE, ignored while busy or in DONE.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op[1:0]      : run request and expected function (00 NAND3, 01 NOR3, 10 XOR3, 11 AND3)
//   a, b, c             : registered stimulus to the gate under test (a = MSB of vector)
//   d                   : response from the gate under test
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   pass, err_count     : all vectors matched / number of mismatching vectors
//   fail_valid, fail_vec: a mismatch was seen / vector of the first mismatch
module gate_truth_table_sequencer #(
    // Cycles each vector is held before it is checked; meaningful range 1..15.
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Settle counter counts 0..SETTLE_CYCLES-1 inside DRIVE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    state_t     state_q,      state_d;
    logic [2:0] vec_q,        vec_d;
    logic [3:0] settle_q,     settle_d;
    logic [1:0] op_q,         op_d;
    logic [2:0] abc_q,        abc_d;
    logic       busy_q,       busy_d;
    logic       done_q,       done_d;
    logic       pass_q,       pass_d;
    logic [3:0] err_count_q,  err_count_d;
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] fail_vec_q,   fail_vec_d;

    logic       expected;
    logic       mismatch;

    // Expected gate response for the vector currently on the pins.
    always_comb begin
        expected = 1'b0;
        case (op_q)
            OP_NAND: expected = ~(abc_q[2] & abc_q[1] & abc_q[0]);
            OP_NOR:  expected = ~(abc_q[2] | abc_q[1] | abc_q[0]);
            OP_XOR:  expected =   abc_q[2] ^ abc_q[1] ^ abc_q[0];
            OP_AND:  expected =   abc_q[2] & abc_q[1] & abc_q[0];
            default: expected = 1'b0;
        endcase
    end

    assign mismatch = (state_q == CHECK) && (d != expected);

    // Next-state and result bookkeeping.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        op_d         = op_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = DRIVE;
                    op_d         = op;
                    vec_d        = 3'd0;
                    settle_d     = 4'd0;
                    pass_d       = 1'b0;
                    err_count_d  = 4'd0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 3'd0;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = CHECK;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + 4'd1;
                    // Only the first failing vector is recorded.
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                    // Uses the updated count so the last vector's result is included.
                    pass_d  = (err_count_d == 4'd0);
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered off the next state so the new vector is on the pins
    // during the very first DRIVE cycle.
    always_comb begin
        busy_d = (state_d == DRIVE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        abc_d  = busy_d ? vec_d : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= 3'd0;
            settle_q     <= 4'd0;
            op_q         <= 2'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            op_q         <= op_d;
            abc_q        <= abc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign a          = abc_q[2];
    assign b          = abc_q[1];
    assign c          = abc_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule
